// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: FSM state, register index and queued write entry.
package wb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wb_state_e;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t            rd;
    logic [XLEN-1:0]     data;
  } wb_entry_t;

  // x0 is hard-wired zero, so a result aimed at it is consumed without a write
  function automatic logic writes_reg(input reg_idx_t rd);
    return (rd != 5'd0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order load-result queue. Pointers carry one extra wrap bit so full and empty
// differ only in the MSB.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_b,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  wb_entry_t   mem_r [DEPTH];
  logic        push_s;
  logic        pop_s;

  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign head   = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer and storage update
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_entry;
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take absolute priority over queued loads; on halt the
// queue drains before halted rises. Define WB_BYPASS_EN to let idle-cycle loads skip the queue.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            halt_req,
  output logic [4:0]      rd_num,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_we,
  output logic            busy,
  output logic            halted,
  output logic [31:0]     wb_count
);

  import wb_pkg::*;

  wb_state_e       state_r;
  wb_state_e       next_state_s;
  wb_entry_t       ld_entry_s;
  wb_entry_t       head_s;
  wb_entry_t       take_entry_s;
  logic            take_s;
  logic            we_next_s;
  logic            bypass_s;
  logic            ld_ready_s;
  logic            fifo_push_s;
  logic            fifo_pop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [4:0]      rd_num_r;
  logic [XLEN-1:0] rd_data_r;
  logic            rd_we_r;
  logic [31:0]     wb_count_r;

  assign ld_entry_s  = '{rd: ld_rd, data: ld_data};
  assign fifo_push_s = ld_valid && ld_ready_s && !bypass_s;
  assign we_next_s   = take_s && writes_reg(take_entry_s.rd);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .push       (fifo_push_s),
    .push_entry (ld_entry_s),
    .pop        (fifo_pop_s),
    .head       (head_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state: the drain ends only once the final write has already been committed
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RUN: begin
        if (halt_req) next_state_s = DRAIN;
        else          next_state_s = RUN;
      end
      DRAIN: begin
        if (fifo_empty_s && !rd_we_r) next_state_s = HALTED;
        else                          next_state_s = DRAIN;
      end
      HALTED:  next_state_s = HALTED;
      default: next_state_s = RUN;
    endcase
  end

  // Arbitration: select what the output register captures this cycle
  always_comb begin
    ld_ready_s   = 1'b0;
    bypass_s     = 1'b0;
    fifo_pop_s   = 1'b0;
    take_s       = 1'b0;
    take_entry_s = head_s;
    case (state_r)
      RUN: begin
        ld_ready_s = !fifo_full_s;
`ifdef WB_BYPASS_EN
        bypass_s   = ld_valid && fifo_empty_s && !alu_valid;
`else
        bypass_s   = 1'b0;
`endif
        if (alu_valid) begin
          take_s       = 1'b1;
          take_entry_s = '{rd: alu_rd, data: alu_data};
        end else if (bypass_s) begin
          take_s       = 1'b1;
          take_entry_s = ld_entry_s;
        end else if (!fifo_empty_s) begin
          take_s     = 1'b1;
          fifo_pop_s = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      DRAIN: begin
        if (!fifo_empty_s) begin
          take_s     = 1'b1;
          fifo_pop_s = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      HALTED:  take_s = 1'b0;
      default: take_s = 1'b0;
    endcase
  end

  // Registered write port and commit counter
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_num_r   <= 5'd0;
      rd_data_r  <= '0;
      rd_we_r    <= 1'b0;
      wb_count_r <= 32'd0;
    end else begin
      rd_we_r <= we_next_s;
      if (take_s) begin
        rd_num_r  <= take_entry_s.rd;
        rd_data_r <= take_entry_s.data;
      end
      if (we_next_s) begin
        wb_count_r <= wb_count_r + 32'd1;
      end
    end
  end

  assign ld_ready = ld_ready_s;
  assign rd_num   = rd_num_r;
  assign rd_data  = rd_data_r;
  assign rd_we    = rd_we_r;
  assign wb_count = wb_count_r;
  assign busy     = !fifo_empty_s || rd_we_r;
  assign halted   = (state_r == HALTED);

endmodule
